// File: rtl/stage_if_pkg.sv
// Shared pipeline definitions for the fetch stage and the IF/ID boundary.
// The hazard unit and decode reuse the IF/ID record type.
package stage_if_pkg;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pc_four;
        logic        valid;
    } if_id_t;

    typedef enum logic [1:0] {
        IFID_LOAD   = 2'd0,
        IFID_HOLD   = 2'd1,
        IFID_BUBBLE = 2'd2
    } if_id_op_t;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/stage_if_reg_if_id.sv
// IF/ID pipeline register: load, hold (stall) or bubble (flush/redirect).
// A bubble replaces the instruction with a NOP but leaves the PC fields alone.
module stage_if_reg_if_id
    import stage_if_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic      clk,
    input  logic      reset,
    input  if_id_op_t op,
    input  if_id_t    d,
    output if_id_t    q
);

    if_id_t q_next;

    always_comb begin
        q_next = q;
        case (op)
            IFID_LOAD: begin
                q_next = d;
            end
            IFID_BUBBLE: begin
                q_next.instr = NOP_INSTR;
                q_next.valid = 1'b0;
            end
            default: begin
                q_next = q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q.instr   <= NOP_INSTR;
            q.pc      <= 32'h0000_0000;
            q.pc_four <= 32'h0000_0000;
            q.valid   <= 1'b0;
        end else begin
            q <= q_next;
        end
    end

endmodule

// File: rtl/stage_if.sv
// Fetch stage: PC register, next-PC selection and the IF/ID register.
// Instruction memory is read combinationally at the current PC.
module stage_if
    import stage_if_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_stall,
    input  logic        i_flush,
    input  logic        i_redirect,
    input  logic [31:0] i_redirect_pc,
    input  logic [31:0] i_imem_rdata,
    output logic [31:0] o_imem_addr,
    output logic [31:0] o_instr_id,
    output logic [31:0] o_pc_id,
    output logic [31:0] o_pc_four_id,
    output logic        o_valid_id,
    output logic        o_fetch_err
);

    logic [31:0] pc_if;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        fetch_err;
    logic        misaligned;
    if_id_op_t   if_id_op;
    if_id_t      if_id_d;
    if_id_t      if_id_q;

    assign pc_plus4   = pc_if + 32'd4;
    assign misaligned = i_redirect && (i_redirect_pc[1:0] != 2'b00);

    // Redirect comes from EX and is older than any stall, so it wins.
    always_comb begin
        pc_next = pc_plus4;
        if (i_redirect) begin
            pc_next = align_word(i_redirect_pc);
        end else if (i_stall) begin
            pc_next = pc_if;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pc_if     <= RESET_PC;
            fetch_err <= 1'b0;
        end else begin
            pc_if <= pc_next;
            if (misaligned) begin
                fetch_err <= 1'b1;
            end
        end
    end

    // A wrong-path instruction must never be held in ID across a redirect.
    always_comb begin
        if_id_op = IFID_LOAD;
        if (i_redirect || i_flush) begin
            if_id_op = IFID_BUBBLE;
        end else if (i_stall) begin
            if_id_op = IFID_HOLD;
        end
    end

    always_comb begin
        if_id_d.instr   = i_imem_rdata;
        if_id_d.pc      = pc_if;
        if_id_d.pc_four = pc_plus4;
        if_id_d.valid   = 1'b1;
    end

    stage_if_reg_if_id #(
        .NOP_INSTR (NOP_INSTR)
    ) u_reg_if_id (
        .clk   (i_clk),
        .reset (i_reset),
        .op    (if_id_op),
        .d     (if_id_d),
        .q     (if_id_q)
    );

    assign o_imem_addr  = pc_if;
    assign o_instr_id   = if_id_q.instr;
    assign o_pc_id      = if_id_q.pc;
    assign o_pc_four_id = if_id_q.pc_four;
    assign o_valid_id   = if_id_q.valid;
    assign o_fetch_err  = fetch_err;

endmodule

// File: tb/tb_stage_if.sv
// Directed vector bench for stage_if: each row gives inputs for one edge and
// the outputs expected just after it; imem returns addr ^ key.
module tb_stage_if;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] KEY = 32'hA5A5_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] imem_rdata;
    logic [31:0] imem_addr;
    logic [31:0] instr_id;
    logic [31:0] pc_id;
    logic [31:0] pc_four_id;
    logic        valid_id;
    logic        fetch_err;
    logic [31:0] imem_key;

    int n_cmp;
    int n_err;

    stage_if dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_stall       (stall),
        .i_flush       (flush),
        .i_redirect    (redirect),
        .i_redirect_pc (redirect_pc),
        .i_imem_rdata  (imem_rdata),
        .o_imem_addr   (imem_addr),
        .o_instr_id    (instr_id),
        .o_pc_id       (pc_id),
        .o_pc_four_id  (pc_four_id),
        .o_valid_id    (valid_id),
        .o_fetch_err   (fetch_err)
    );

    assign imem_rdata = imem_addr ^ imem_key;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        stl;
        logic        fls;
        logic        red;
        logic [31:0] rpc;
        logic [31:0] addr;
        logic [31:0] instr;
        logic [31:0] pcid;
        logic [31:0] pc4;
        logic        vld;
        logic        err;
    } vec_t;

    localparam int NV = 31;
    vec_t vecs [NV];

    function automatic logic [31:0] im(input logic [31:0] a);
        return a ^ KEY;
    endfunction

    function automatic vec_t mk(input logic rst, input logic stl, input logic fls,
                                input logic red, input logic [31:0] rpc,
                                input logic [31:0] addr, input logic [31:0] instr,
                                input logic [31:0] pcid, input logic [31:0] pc4,
                                input logic vld, input logic err);
        vec_t v;
        v.rst = rst; v.stl = stl; v.fls = fls; v.red = red; v.rpc = rpc;
        v.addr = addr; v.instr = instr; v.pcid = pcid; v.pc4 = pc4;
        v.vld = vld; v.err = err;
        return v;
    endfunction

    task automatic chk(input string name, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (step %0d): got %h, expected %h", name, idx, act, exp);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        imem_key = KEY;
        reset = 1'b1; stall = 1'b0; flush = 1'b0; redirect = 1'b0; redirect_pc = '0;

        //               rst stl fls red rpc            addr           instr              pc_id          pc4            v  e
        vecs[0]  = mk(1, 0, 0, 0, 32'h0,         32'h0,         NOP,               32'h0,         32'h0,         0, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,         32'h4,         im(32'h0),         32'h0,         32'h4,         1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 32'h0,         32'h8,         im(32'h4),         32'h4,         32'h8,         1, 0);
        vecs[3]  = mk(0, 0, 0, 0, 32'h0,         32'hC,         im(32'h8),         32'h8,         32'hC,         1, 0);
        vecs[4]  = mk(0, 0, 0, 0, 32'h0,         32'h10,        im(32'hC),         32'hC,         32'h10,        1, 0);
        vecs[5]  = mk(0, 1, 0, 0, 32'h0,         32'h10,        im(32'hC),         32'hC,         32'h10,        1, 0);
        vecs[6]  = mk(0, 1, 0, 0, 32'h0,         32'h10,        im(32'hC),         32'hC,         32'h10,        1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 32'h0,         32'h14,        im(32'h10),        32'h10,        32'h14,        1, 0);
        vecs[8]  = mk(0, 0, 0, 0, 32'h0,         32'h18,        im(32'h14),        32'h14,        32'h18,        1, 0);
        vecs[9]  = mk(0, 0, 0, 0, 32'h0,         32'h1C,        im(32'h18),        32'h18,        32'h1C,        1, 0);
        vecs[10] = mk(0, 0, 0, 0, 32'h0,         32'h20,        im(32'h1C),        32'h1C,        32'h20,        1, 0);
        vecs[11] = mk(0, 0, 0, 1, 32'h200,       32'h200,       NOP,               32'h1C,        32'h20,        0, 0);
        vecs[12] = mk(0, 0, 0, 0, 32'h0,         32'h204,       im(32'h200),       32'h200,       32'h204,       1, 0);
        vecs[13] = mk(0, 1, 0, 1, 32'h300,       32'h300,       NOP,               32'h200,       32'h204,       0, 0);
        vecs[14] = mk(0, 0, 0, 0, 32'h0,         32'h304,       im(32'h300),       32'h300,       32'h304,       1, 0);
        vecs[15] = mk(0, 0, 1, 0, 32'h0,         32'h308,       NOP,               32'h300,       32'h304,       0, 0);
        vecs[16] = mk(0, 1, 1, 0, 32'h0,         32'h308,       NOP,               32'h300,       32'h304,       0, 0);
        vecs[17] = mk(0, 0, 0, 0, 32'h0,         32'h30C,       im(32'h308),       32'h308,       32'h30C,       1, 0);
        vecs[18] = mk(0, 0, 0, 1, 32'h102,       32'h100,       NOP,               32'h308,       32'h30C,       0, 1);
        vecs[19] = mk(0, 0, 0, 0, 32'h0,         32'h104,       im(32'h100),       32'h100,       32'h104,       1, 1);
        vecs[20] = mk(0, 0, 0, 0, 32'h0,         32'h108,       im(32'h104),       32'h104,       32'h108,       1, 1);
        vecs[21] = mk(0, 0, 0, 0, 32'h0,         32'h10C,       im(32'h108),       32'h108,       32'h10C,       1, 1);
        vecs[22] = mk(0, 0, 0, 0, 32'h0,         32'h110,       im(32'h10C),       32'h10C,       32'h110,       1, 1);
        vecs[23] = mk(0, 0, 0, 0, 32'h0,         32'h114,       im(32'h110),       32'h110,       32'h114,       1, 1);
        vecs[24] = mk(0, 0, 0, 1, 32'hFFFF_FFFC, 32'hFFFF_FFFC, NOP,               32'h110,       32'h114,       0, 1);
        vecs[25] = mk(0, 0, 0, 0, 32'h0,         32'h0,         im(32'hFFFF_FFFC), 32'hFFFF_FFFC, 32'h0,         1, 1);
        vecs[26] = mk(0, 0, 0, 0, 32'h0,         32'h4,         im(32'h0),         32'h0,         32'h4,         1, 1);
        vecs[27] = mk(0, 1, 0, 0, 32'h0,         32'h4,         im(32'h0),         32'h0,         32'h4,         1, 1);
        vecs[28] = mk(1, 1, 0, 0, 32'h0,         32'h0,         NOP,               32'h0,         32'h0,         0, 0);
        vecs[29] = mk(1, 0, 0, 1, 32'h55,        32'h0,         NOP,               32'h0,         32'h0,         0, 0);
        vecs[30] = mk(0, 0, 0, 0, 32'h0,         32'h4,         im(32'h0),         32'h0,         32'h4,         1, 0);

        @(posedge clk);
        #1;
        for (int i = 0; i < NV; i++) begin
            reset       = vecs[i].rst;
            stall       = vecs[i].stl;
            flush       = vecs[i].fls;
            redirect    = vecs[i].red;
            redirect_pc = vecs[i].rpc;
            @(posedge clk);
            #1;
            chk("imem_addr",  i, imem_addr,  vecs[i].addr);
            chk("instr_id",   i, instr_id,   vecs[i].instr);
            chk("pc_id",      i, pc_id,      vecs[i].pcid);
            chk("pc_four_id", i, pc_four_id, vecs[i].pc4);
            chk("valid_id",   i, {31'b0, valid_id},  {31'b0, vecs[i].vld});
            chk("fetch_err",  i, {31'b0, fetch_err}, {31'b0, vecs[i].err});
        end

        // imem data must only reach the outputs through the IF/ID register.
        reset = 1'b0; stall = 1'b0; flush = 1'b0; redirect = 1'b0;
        imem_key = 32'hDEAD_0000;
        #2;
        chk("no_comb_instr", 100, instr_id,  im(32'h0));
        chk("no_comb_addr",  100, imem_addr, 32'h4);
        @(posedge clk);
        #1;
        chk("key_loaded", 101, instr_id, 32'h4 ^ 32'hDEAD_0000);
        chk("key_pc_id",  101, pc_id,    32'h4);
        imem_key = KEY;

        // Misaligned redirect under stall: still sets the error, target aligned.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0403;
        @(posedge clk);
        #1;
        stall = 1'b0; redirect = 1'b0;
        chk("mis_addr",  102, imem_addr, 32'h400);
        chk("mis_err",   102, {31'b0, fetch_err}, 32'h1);
        chk("mis_valid", 102, {31'b0, valid_id},  32'h0);
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("mis_sticky", 103 + k, {31'b0, fetch_err}, 32'h1);
        end
        chk("mis_run_addr", 106, imem_addr, 32'h40C);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/stage_if.md
Name: stage_if

Overview:
- Fetch stage plus IF/ID pipeline register for the non-forwarding 5-stage RV32I pipeline; sits directly upstream of the decode stage.
- Holds the PC and drives the instruction-memory address (combinational read).
- Registers instr/pc/pc+4 into IF/ID for decode.
- Applies stall (hazard hold), redirect (taken branch/jump resolved in EX) and flush (bubble insertion).

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0013, bubble encoding (addi x0,x0,0)

Ports:
- i_clk  in  1  clock; all state updates on rising edge
- i_reset  in  1  synchronous, active-high reset
- i_stall  in  1  hold PC and IF/ID contents (load-use/RAW hazard from hazard unit)
- i_flush  in  1  load a bubble into IF/ID next edge
- i_redirect  in  1  taken branch/jump from EX (pc_sel)
- i_redirect_pc  in  32  redirect target
- i_imem_rdata  in  32  instruction at o_imem_addr, same cycle
- o_imem_addr  out  32  current PC (pc_if)
- o_instr_id  out  32  IF/ID instruction
- o_pc_id  out  32  IF/ID PC
- o_pc_four_id  out  32  IF/ID PC+4
- o_valid_id  out  1  IF/ID holds a real instruction (0 = bubble)
- o_fetch_err  out  1  sticky: misaligned redirect seen

Behaviour:
- Reset (sync, i_reset=1 at edge): pc_if=RESET_PC, o_instr_id=NOP_INSTR, o_pc_id=0, o_pc_four_id=0, o_valid_id=0, o_fetch_err=0. Reset overrides all other inputs.
- o_imem_addr = pc_if, combinational from register. Fetch latency is 0 cycles to read data and 1 cycle into IF/ID.
- PC next-state priority: redirect > stall > sequential.
  - redirect=1: pc_if <= {i_redirect_pc[31:2],2'b00}, regardless of i_stall.
  - stall=1 (no redirect): pc_if holds.
  - Otherwise: pc_if <= pc_if+4. The 32-bit add wraps, so 0xFFFF_FFFC -> 0x0000_0000.
- IF/ID next-state priority: (redirect or flush) > stall > load.
  - Bubble: o_instr_id=NOP_INSTR, o_valid_id=0, o_pc_id and o_pc_four_id hold previous values.
  - Stall: all IF/ID outputs hold.
  - Load: o_instr_id=i_imem_rdata, o_pc_id=pc_if, o_pc_four_id=pc_if+4 (wraps), o_valid_id=1.
- Simultaneous stall+redirect: the redirect is older (it is in EX), so the PC redirects and IF/ID bubbles. The wrong-path instruction in ID must not persist.
- Simultaneous stall+flush (no redirect): PC holds and IF/ID bubbles.
- o_fetch_err is set when i_redirect=1 and i_redirect_pc[1:0]!=0. It stays set until reset. Target low bits are still forced to 00.
- Reset asserted mid-stall or mid-redirect: the reset values win that edge. First fetch after deassertion is at RESET_PC.
- No combinational path from i_imem_rdata to any output.

Decomposition:
- Shared package (existing pipeline pkg) holds:
  - NOP_INSTR constant
  - RESET_PC default
  - an if_id_t packed struct {instr, pc, pc_four, valid}, reused by the hazard unit and decode.
- One natural sub-module: reg_if_id, the IF/ID register with stall/flush enables. The PC register and next-PC mux stay in stage_if.

Test Plan:
- Reset then 3 free-run cycles, with imem returning addr^0xA5A5_0000:
  - o_imem_addr steps 0,4,8.
  - o_pc_id 0 then 4, with o_instr_id matching the imem data.
  - o_valid_id 0 then 1.
- Stall held 2 cycles at pc_if=0x10:
  - o_imem_addr stays 0x10.
  - IF/ID outputs frozen.
  - On release, fetch resumes at 0x10 then 0x14, with no skipped or duplicated instruction.
- Redirect to 0x200 while pc_if=0x20:
  - Next cycle o_imem_addr=0x200.
  - IF/ID = NOP_INSTR with o_valid_id=0.
  - Following cycle o_pc_id=0x200, o_pc_four_id=0x204.
- Redirect and stall together, target 0x300:
  - PC=0x300.
  - IF/ID bubble, not held.
- Redirect to 0x102:
  - o_imem_addr=0x100 and o_fetch_err=1.
  - o_fetch_err remains 1 over 5 further cycles.
  - Cleared only by i_reset.
- Wrap and mid-flight reset:
  - Redirect to 0xFFFF_FFFC, then free-run: o_pc_four_id=0 and next PC=0.
  - Assert i_reset during a stall: all outputs return to reset values on that edge.
